uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial UART receiver that deserialises the asynchronous rx line into parallel bytes.
- Asserts a one-cycle rx_interrupt pulse per valid frame. That pulse drives the rx_interrupt input of the interrupt flag register, which holds it until software clears it.
- Sits between the board RX pin and the interrupt flag register / data consumer.
- Frame format: 1 start bit, DATA_WIDTH data bits LSB first, optional even-parity bit, 1 stop bit.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s. BIT_CYCLES = CLK_FREQ/BAUD_RATE (integer divide) must be >= 4.
- DATA_WIDTH, 8: data bits per frame, 5..9.
- PARITY_EN, 0: 1 means an even-parity bit follows the data bits; 0 means no parity bit.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous active-low reset.
- rx, input, 1: asynchronous serial line, idle high.
- rx_data, output, DATA_WIDTH: last correctly framed byte, held until the next valid frame.
- rx_interrupt, output, 1: one-cycle pulse when rx_data and parity_error update.
- parity_error, output, 1: parity status of the frame currently in rx_data. Always 0 when PARITY_EN=0.
- frame_error, output, 1: one-cycle pulse when a stop bit is sampled low.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Clock and reset:
  - Single clock domain; reset is asynchronous and active-low.
  - On rst=0, all outputs are 0 and the FSM is in IDLE. The synchroniser flops reset to 1 (line idle).
- rx is double-flopped to rx_sync. A falling edge is defined as rx_sync previous = 1 and current = 0.
- Bit timer: counter of width $clog2(BIT_CYCLES), cleared on every state entry. HALF = BIT_CYCLES/2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a rx_sync falling edge, go to START and clear the counter. No other event leaves IDLE.
  - START: when counter = HALF-1, sample rx_sync.
    - 0: go to DATA.
    - 1: false start (glitch); go to IDLE with no output change.
  - DATA: when counter = BIT_CYCLES-1, sample rx_sync into the shift register (LSB first) and increment the bit index.
    - After DATA_WIDTH samples, go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: when counter = BIT_CYCLES-1, sample the parity bit. perr = XOR(data bits, parity bit); even parity, so perr = 1 means error. Go to STOP.
  - STOP: when counter = BIT_CYCLES-1, sample rx_sync.
    - 1: on the next edge, rx_data <= shift register, parity_error <= perr, and rx_interrupt = 1 for exactly one cycle.
    - 0: frame_error = 1 for one cycle; rx_data, parity_error and rx_interrupt are unchanged.
    - Either way, go to IDLE.
- Sampling point: every data, parity and stop bit is sampled at its nominal mid-bit point.
- Latency: 2 cycles synchroniser + HALF + (DATA_WIDTH + PARITY_EN + 1)·BIT_CYCLES + 1 cycle from the rx falling edge to rx_interrupt high.
- Line held low (break) after a framing error: no new start is detected until rx_sync returns high and falls again.
- Back-to-back frames: a start edge immediately after the stop-bit sample is detected, because IDLE is re-entered mid stop bit with the line high.
- Reset mid-frame: aborts immediately and discards the partial byte. The next full frame after reset release is received correctly.
- Consumer timing: rx_interrupt is never held. If the consumer misses the pulse, the frame is lost; the downstream flag register captures it.

Decomposition:
- uart_pkg:
  - TRUE/FALSE constants (existing).
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP}.
  - Function bit_cycles(clk_freq, baud) returning the integer divide.
- Sub-module uart_bit_timer:
  - Inputs: clear, terminal value.
  - Output: tick pulse.
  - Parameterised by counter width; reusable by the future uart_tx.
- Synchroniser and edge detect stay inline in uart_rx.

Test Plan:
Bench parameters: CLK_FREQ=1_600_000, BAUD_RATE=100_000 (BIT_CYCLES=16), DATA_WIDTH=8.
1. PARITY_EN=0, send 0xA5 -> exactly one rx_interrupt pulse 2+8+144+1=155 cycles after the rx fall; rx_data=0xA5, parity_error=0, frame_error never high.
2. PARITY_EN=1: 0x3C with parity bit 0 -> rx_data=0x3C, parity_error=0. Then 0x3C with parity bit 1 -> rx_interrupt pulses, parity_error=1.
3. rx low for 4 cycles, then high -> START aborts at the mid-bit sample; busy returns to 0; no rx_interrupt or frame_error.
4. Send 0x55 with stop bit 0, line held low 5 bit-times -> single frame_error pulse, no rx_interrupt, rx_data keeps the previous 0xA5. After the line goes high, 0x12 is received normally.
5. Assert rst mid-frame after 3 data bits -> all outputs 0 asynchronously. After release, 0x81 is received correctly with one rx_interrupt.
6. Back-to-back 0x01 then 0xFF, no idle gap -> two rx_interrupt pulses 160 cycles apart; rx_data=0x01 then 0xFF.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: boolean constants, receiver state encoding and
// the baud-divisor helper used by both the receiver and the future transmitter.
`timescale 1ns/1ps

package uart_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Receiver frame-walk states; IDLE is the only non-busy state.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Clock cycles per bit (integer divide, truncating).
  function automatic int bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit timer: counts clock cycles and pulses tick when the count
// reaches the terminal value, then restarts from zero. A clear restarts the
// count so every state can measure from its own entry point.
`timescale 1ns/1ps

module uart_bit_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] terminal,
  output logic             tick
);

  logic [WIDTH-1:0] count;

  assign tick = (count == terminal);

  // Count cycles; wrap on the terminal value or restart on clear.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    if (!rst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises the rx line, detects the start edge, samples
// each bit at its mid-point and presents complete frames as a parallel word
// with a one-cycle rx_interrupt pulse. A low stop bit yields a one-cycle
// frame_error pulse and leaves the previously received word untouched.
`timescale 1ns/1ps

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_interrupt,
  output logic                  parity_error,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD_RATE);
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam int IDX_W      = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] FULL_TERM = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_WIDTH - 1);
  localparam logic             HAS_PAR   = (PARITY_EN != 0);

  // Synchroniser and edge detector
  logic rx_meta;
  logic rx_sync;
  logic rx_prev;
  logic start_edge;

  // FSM and timing
  rx_state_t        state;
  rx_state_t        state_next;
  logic             timer_clear;
  logic [CNT_W-1:0] timer_term;
  logic             tick;

  // Datapath
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  perr;
  logic                  sample_data;
  logic                  sample_parity;
  logic                  stop_good;
  logic                  stop_bad;

  // Double-flop the asynchronous line and keep one extra stage for edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // Synchroniser resets to the idle line level so reset release is
      // never mistaken for a start edge.
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign start_edge = rx_prev & ~rx_sync;

  // Bit timer, restarted on every state entry.
  uart_bit_timer #(
    .WIDTH (CNT_W)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .terminal (timer_term),
    .tick     (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: walk the frame one sampled bit at a time.
  always_comb begin
    // NOTE: a default assignment ahead of the case keeps every path driven,
    // so no latch is inferred for state_next.
    state_next = state;
    case (state)
      IDLE: begin
        if (start_edge) state_next = START;
      end
      START: begin
        if (tick) state_next = rx_sync ? IDLE : DATA;
      end
      DATA: begin
        if (tick && (bit_idx == LAST_BIT)) state_next = HAS_PAR ? PARITY : STOP;
      end
      PARITY: begin
        if (tick) state_next = STOP;
      end
      STOP: begin
        if (tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output/control decode from the current state.
  always_comb begin
    busy          = (state != IDLE);
    timer_clear   = (state_next != state) ? TRUE : FALSE;
    timer_term    = (state == START) ? HALF_TERM : FULL_TERM;
    sample_data   = (state == DATA)   && tick;
    sample_parity = (state == PARITY) && tick;
    stop_good     = (state == STOP)   && tick &&  rx_sync;
    stop_bad      = (state == STOP)   && tick && !rx_sync;
  end

  // Bit index: counts data samples within the DATA state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_idx <= '0;
    end else if (state != DATA) begin
      bit_idx <= '0;
    end else if (tick) begin
      bit_idx <= bit_idx + IDX_W'(1);
    end
  end

  // Shift register: data arrives LSB first, so shift in from the top.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the shift register is reset along with the control flops so a
    // frame aborted by reset can never leak stale or X bits into rx_data.
    if (!rst) begin
      shift_reg <= '0;
    end else if (sample_data) begin
      shift_reg <= {rx_sync, shift_reg[DATA_WIDTH-1:1]};
    end
  end

  // Even-parity check: XOR of data and parity bit is 1 on error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perr <= FALSE;
    end else if (sample_parity) begin
      perr <= (^shift_reg) ^ rx_sync;
    end
  end

  // Frame result registers: publish on a good stop bit, flag a bad one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data      <= '0;
      parity_error <= FALSE;
      rx_interrupt <= FALSE;
      frame_error  <= FALSE;
    end else begin
      rx_interrupt <= stop_good;
      frame_error  <= stop_bad;
      if (stop_good) begin
        rx_data      <= shift_reg;
        parity_error <= HAS_PAR ? perr : FALSE;
      end
    end
  end

endmodule
